// File: rtl/tsc_fifo_v2_pkg.sv
// Shared constants, types and pointer-code helpers for the tsc_fifo_v2 write/read controllers.
package tsc_fifo_v2_pkg;

    localparam int unsigned TSC_AW = 10;
    localparam int unsigned TSC_PW = 11;
    localparam int unsigned TSC_DW = 32;

    typedef struct packed {
        logic [TSC_AW-1:0] addr;
        logic [TSC_DW-1:0] data;
    } tsc_wr_t;

    function automatic logic [TSC_PW-1:0] bin2gray(input logic [TSC_PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [TSC_PW-1:0] gray2bin(input logic [TSC_PW-1:0] g);
        logic [TSC_PW-1:0] b;
        b[TSC_PW-1] = g[TSC_PW-1];
        for (int i = TSC_PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/tsc_fifo_v2_sync.sv
// Multi-flop synchronizer with synchronous clear; shared by both FIFO controller sides.
module tsc_fifo_v2_sync
    import tsc_fifo_v2_pkg::*;
#(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = TSC_PW
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tsc_fifo_v2_wctl.sv
// Write-side FIFO controller: byte-to-word packing, Gray write pointer and full flag.
// Optional occupancy outputs (wlevel, almost_full) are built when TSC_FIFO_WCTL_LEVEL_EN is defined.
module tsc_fifo_v2_wctl
    import tsc_fifo_v2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
`ifdef TSC_FIFO_WCTL_LEVEL_EN
    ,
    parameter int unsigned AF_THRESH   = 1000
`endif
) (
    input  logic              clkw,
    input  logic              rstw,
    input  logic [7:0]        din,
    input  logic              din_vld,
    input  logic              din_last,
    output logic              din_rdy,
    input  logic [TSC_PW-1:0] rptr_gray,
    output logic [TSC_PW-1:0] wptr_gray,
    output logic              full,
    output logic [TSC_AW-1:0] aw,
    output logic              cew,
    output logic [TSC_DW-1:0] dw
`ifdef TSC_FIFO_WCTL_LEVEL_EN
    ,
    output logic [TSC_PW-1:0] wlevel,
    output logic              almost_full
`endif
);

    logic [1:0]        bcnt_q, bcnt_d;
    logic [TSC_DW-1:0] pack_q, pack_d;
    logic [TSC_DW-1:0] word;
    logic [TSC_PW-1:0] wptr_bin_q, wptr_bin_d;
    logic [TSC_PW-1:0] wptr_gray_q, wptr_gray_d;
    logic [TSC_PW-1:0] rptr_sync;
    logic              full_q, full_d;
    tsc_wr_t           wr_q, wr_d;
    logic              cew_q;
    logic              accept;
    logic              commit;

    tsc_fifo_v2_sync #(
        .STAGES(SYNC_STAGES),
        .WIDTH (TSC_PW)
    ) u_rptr_sync (
        .clk(clkw),
        .clr(rstw),
        .d  (rptr_gray),
        .q  (rptr_sync)
    );

    assign din_rdy = ~full_q & ~rstw;

    always_comb begin
        accept = din_vld & din_rdy;
        // din_last on lane 3 still yields a single commit
        commit = accept & ((bcnt_q == 2'd3) | din_last);

        // Lanes above bcnt are already zero because the pack register clears on commit
        word = pack_q;
        word[{bcnt_q, 3'b000} +: 8] = din;

        bcnt_d     = bcnt_q;
        pack_d     = pack_q;
        wptr_bin_d = wptr_bin_q;
        wr_d       = wr_q;

        if (commit) begin
            bcnt_d     = 2'd0;
            pack_d     = '0;
            wptr_bin_d = wptr_bin_q + 11'd1;
            wr_d.addr  = wptr_bin_q[TSC_AW-1:0];
            wr_d.data  = word;
        end else if (accept) begin
            bcnt_d = bcnt_q + 2'd1;
            pack_d = word;
        end

        wptr_gray_d = bin2gray(wptr_bin_d);
        // Full when write pointer leads read pointer by exactly one lap
        full_d = (wptr_gray_d == {~rptr_sync[TSC_PW-1:TSC_PW-2], rptr_sync[TSC_PW-3:0]});
    end

    always_ff @(posedge clkw) begin
        if (rstw) begin
            bcnt_q      <= 2'd0;
            pack_q      <= '0;
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            full_q      <= 1'b0;
            wr_q        <= '0;
            cew_q       <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            pack_q      <= pack_d;
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
            full_q      <= full_d;
            wr_q        <= wr_d;
            cew_q       <= commit;
        end
    end

    assign wptr_gray = wptr_gray_q;
    assign full      = full_q;
    assign aw        = wr_q.addr;
    assign dw        = wr_q.data;
    assign cew       = cew_q;

`ifdef TSC_FIFO_WCTL_LEVEL_EN
    localparam logic [TSC_PW-1:0] AfLevel = AF_THRESH[TSC_PW-1:0];

    logic [TSC_PW-1:0] wlevel_q, wlevel_d;
    logic              almost_full_q, almost_full_d;

    always_comb begin
        wlevel_d      = wptr_bin_d - gray2bin(rptr_sync);
        almost_full_d = (wlevel_d >= AfLevel);
    end

    always_ff @(posedge clkw) begin
        if (rstw) begin
            wlevel_q      <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wlevel_q      <= wlevel_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign wlevel      = wlevel_q;
    assign almost_full = almost_full_q;
`endif

endmodule
